bwn_frame_ctrl: RTL and testbench
=================================

Name: bwn_frame_ctrl

Overview:
Frame-level sequencer for the four-layer binary-weight FC pipeline (FC1..FC4 with parallel-to-serial, BN and ReLU stages, then the class judge). It admits one inference frame of INPUT_SIZE1 samples through a valid/ready handshake and forwards it to FC1 as a single valid strobe stream. It generates all weight and BN-coefficient ROM addresses from the per-layer enable strobes, with correct wrap-around. It watches for the judge result, latches the class, and flags malformed or stalled frames.

Parameters:
INPUT_SIZE1, 1274, samples per frame and FC1 weight-address depth
INPUT_SIZE2, 120, FC2 weight depth; also the BN1 coefficient depth
INPUT_SIZE3, 80, FC3 weight depth; also the BN2 coefficient depth
INPUT_SIZE4, 40, FC4 weight depth; also the BN3 coefficient depth
D_WL, 16, sample word length
AW, 12, width of every address output
TIMEOUT, 4095, maximum idle cycles in WAIT before abort (16-bit counter)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
start  in  1  frame start request; acted on only in IDLE
clr  in  1  synchronous soft abort; forces IDLE and clears all counters
s_valid  in  1  host sample valid
s_data  in  D_WL  host sample
s_ready  out  1  controller accepts sample
dp_valid  out  1  registered sample strobe to FC1 in_valid
dp_data  out  D_WL  registered sample to FC1 x
bn1_en, bn2_en, bn3_en  in  1 each  parallel-serial-to-BN strobes, layers 1..3
fc2_en, fc3_en, fc4_en  in  1 each  ReLU-to-FC strobes, layers 2..4
w1_addr, w2_addr, w3_addr, w4_addr  out  AW each  weight ROM addresses
c1_addr, c2_addr, c3_addr  out  AW each  BN A/B ROM address, shared by A and B
res_valid  in  1  judge o_valid
res_class  in  2  judge result
busy  out  1  high in LOAD or WAIT
done  out  1  one-cycle pulse when a frame completes or aborts
class_out  out  2  class of the last good frame
err  out  2  00 ok, 01 timeout, 10 incomplete frame at result, 11 strobe with no active frame

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE. All addresses 0. s_ready=0, dp_valid=0, dp_data=0, busy=0, done=0, class_out=0, err=0, timeout counter 0. A reset mid-frame discards the frame with no done pulse.
- FSM states: IDLE, LOAD, WAIT, DONE.
- IDLE: s_ready=0. On start=1, go to LOAD and clear err.
- LOAD: s_ready=1. A beat is accepted when s_valid & s_ready. Each accepted beat registers dp_data=s_data and dp_valid=1 on the next cycle (latency 1). No accepted beat gives dp_valid=0. When beat INPUT_SIZE1-1 is accepted, s_ready drops in the same cycle via a registered lookahead, and the FSM goes to WAIT.
- WAIT: s_ready=0. The timeout counter increments each cycle and resets to 0 on any layer strobe. When it reaches TIMEOUT: err=01, done pulse, all addresses cleared, go to IDLE.
- res_valid in WAIT:
  - Latch class_out=res_class.
  - err=00 if every address counter is 0, i.e. all layers consumed whole vectors; otherwise err=10 and class_out is still updated.
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- res_valid in IDLE, LOAD or DONE is ignored.
- Address generators, one counter per output:
  - w1 advances on an accepted host beat, aligned so w1_addr equals the index of the sample on dp_data while dp_valid=1.
  - c1 on bn1_en, w2 on fc2_en, c2 on bn2_en, w3 on fc3_en, c3 on bn3_en, w4 on fc4_en.
  - Each counter increments when its strobe is high. When at depth-1 and strobed, it wraps to 0 in the same step, with no idle cycle needed.
  - Address outputs are the registered counter values.
- Any layer strobe in IDLE sets err=11. Its counter still advances.
- clr has priority over all transitions except rst_n. It clears counters, dp_valid, and s_ready, and gives no done pulse.
- start while busy is ignored.
- start and clr in the same cycle: clr wins.
- Depth compares use AW-bit unsigned arithmetic. Depths above 2^AW are illegal parameters.

Test Plan:
1. Normal frame: start, then 1274 back-to-back beats. Required: dp_valid high 1274 cycles, w1_addr 0..1273 then 0, s_ready low after the last beat. Inject 120/120/80/80/40/40 strobes, then res_valid with class 2 → done pulse, class_out=2, err=00, busy=0.
2. Throttled input: s_valid toggling 1-0. Required: dp_valid follows one cycle later, w1_addr advances only on accepted beats, frame completes after 1274 accepts.
3. Wrap on back-to-back strobes: 240 consecutive bn1_en. Required: c1_addr 0..119, 0..119 with no stall and no skipped value.
4. Timeout: TIMEOUT=20, full input, then no strobes. Required: on cycle 20 of WAIT, err=01, done pulse, all addresses 0, IDLE.
5. Incomplete frame: res_valid while w3_addr=5. Required: err=10, class_out updated, done pulse.
6. Abort and reset: clr at beat 600 → IDLE, w1_addr=0, no done. rst_n low during WAIT → all outputs 0 on the next edge. fc2_en in IDLE → err=11.

Source files
------------

// File: rtl/bwn_frame_ctrl_if.sv
// Host sample stream into the frame controller and the registered sample stream out to FC1.
interface bwn_frame_ctrl_if #(
  parameter int D_WL = 16
);
  // A host beat transfers on a rising edge where s_valid and s_ready are both high.
  // The host holds s_valid/s_data until the transfer (clr and reset excepted).
  // dp_valid/dp_data is a push-only strobe with no backpressure.
  logic            s_valid;
  logic [D_WL-1:0] s_data;
  logic            s_ready;
  logic            dp_valid;
  logic [D_WL-1:0] dp_data;

  modport master (output s_valid, output s_data, input s_ready, input dp_valid, input dp_data);
  modport slave  (input s_valid, input s_data, output s_ready, output dp_valid, output dp_data);
endinterface

// File: rtl/bwn_frame_ctrl.sv
// Frame sequencer for the four-layer binary-weight FC pipeline: admits one frame,
// generates every weight/BN ROM address with wrap, and latches the judge result.
module bwn_frame_ctrl #(
  parameter int INPUT_SIZE1 = 1274,
  parameter int INPUT_SIZE2 = 120,
  parameter int INPUT_SIZE3 = 80,
  parameter int INPUT_SIZE4 = 40,
  parameter int D_WL        = 16,
  parameter int AW          = 12,
  parameter int TIMEOUT     = 4095
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          clr,
  bwn_frame_ctrl_if.slave bus,
  input  logic          bn1_en,
  input  logic          bn2_en,
  input  logic          bn3_en,
  input  logic          fc2_en,
  input  logic          fc3_en,
  input  logic          fc4_en,
  output logic [AW-1:0] w1_addr,
  output logic [AW-1:0] w2_addr,
  output logic [AW-1:0] w3_addr,
  output logic [AW-1:0] w4_addr,
  output logic [AW-1:0] c1_addr,
  output logic [AW-1:0] c2_addr,
  output logic [AW-1:0] c3_addr,
  input  logic          res_valid,
  input  logic [1:0]    res_class,
  output logic          busy,
  output logic          done,
  output logic [1:0]    class_out,
  output logic [1:0]    err,
  output logic [1:0]    state_dbg
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Counter order: w1, c1, w2, c2, w3, c3, w4 (BN depth of layer k equals FC depth of layer k+1).
  localparam int NCNT = 7;
  localparam logic [AW-1:0] LAST [NCNT] = '{
    AW'(INPUT_SIZE1 - 1), AW'(INPUT_SIZE2 - 1), AW'(INPUT_SIZE2 - 1),
    AW'(INPUT_SIZE3 - 1), AW'(INPUT_SIZE3 - 1), AW'(INPUT_SIZE4 - 1), AW'(INPUT_SIZE4 - 1)};
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  state_e          state_q, state_d;
  logic            s_ready_q, s_ready_d;
  logic            dp_valid_q, dp_valid_d;
  logic [D_WL-1:0] dp_data_q, dp_data_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic [1:0]      class_q, class_d;
  logic [1:0]      err_q, err_d;
  logic [15:0]     to_q, to_d;
  logic [AW-1:0]   cnt_q [NCNT];
  logic [AW-1:0]   cnt_d [NCNT];
  logic [AW-1:0]   w1_addr_q, w1_addr_d;
  logic [NCNT-1:0] strobe;
  logic            accept, layer_strobe, all_zero, clear_cnt;

  always_comb begin
    accept       = (state_q == ST_LOAD) && s_ready_q && bus.s_valid;
    strobe       = {fc4_en, bn3_en, fc3_en, bn2_en, fc2_en, bn1_en, accept};
    layer_strobe = |strobe[NCNT-1:1];
    all_zero     = 1'b1;
    for (int i = 0; i < NCNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_q[i] != '0) all_zero = 1'b0;
      if (strobe[i]) cnt_d[i] = (cnt_q[i] == LAST[i]) ? '0 : cnt_q[i] + AW'(1);
    end
    // w1 trails its counter by one cycle so it names the sample currently on dp_data.
    w1_addr_d  = cnt_q[0];
    state_d    = state_q;
    s_ready_d  = 1'b0;
    dp_valid_d = accept;
    dp_data_d  = accept ? bus.s_data : dp_data_q;
    done_d     = 1'b0;
    class_d    = class_q;
    err_d      = err_q;
    to_d       = '0;
    clear_cnt  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD;
          s_ready_d = 1'b1;
          err_d     = 2'b00;
        end
        if (layer_strobe) err_d = 2'b11;
      end
      ST_LOAD: begin
        s_ready_d = 1'b1;
        if (accept && (cnt_q[0] == LAST[0])) begin
          state_d   = ST_WAIT;
          s_ready_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (res_valid) begin
          class_d = res_class;
          err_d   = all_zero ? 2'b00 : 2'b10;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (!layer_strobe) begin
          to_d = to_q + 16'd1;
          if (to_d == TO_LIMIT) begin
            err_d     = 2'b01;
            done_d    = 1'b1;
            state_d   = ST_IDLE;
            clear_cnt = 1'b1;
            to_d      = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (clr) begin
      state_d    = ST_IDLE;
      s_ready_d  = 1'b0;
      dp_valid_d = 1'b0;
      done_d     = 1'b0;
      class_d    = class_q;
      err_d      = err_q;
      to_d       = '0;
      clear_cnt  = 1'b1;
    end
    if (clear_cnt) begin
      for (int i = 0; i < NCNT; i++) cnt_d[i] = '0;
      w1_addr_d = '0;
    end
    busy_d = (state_d == ST_LOAD) || (state_d == ST_WAIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      s_ready_q  <= 1'b0;
      dp_valid_q <= 1'b0;
      dp_data_q  <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      class_q    <= '0;
      err_q      <= '0;
      to_q       <= '0;
      cnt_q      <= '{default: '0};
      w1_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      s_ready_q  <= s_ready_d;
      dp_valid_q <= dp_valid_d;
      dp_data_q  <= dp_data_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      class_q    <= class_d;
      err_q      <= err_d;
      to_q       <= to_d;
      cnt_q      <= cnt_d;
      w1_addr_q  <= w1_addr_d;
    end
  end

  assign bus.s_ready  = s_ready_q;
  assign bus.dp_valid = dp_valid_q;
  assign bus.dp_data  = dp_data_q;
  assign w1_addr      = w1_addr_q;
  assign c1_addr      = cnt_q[1];
  assign w2_addr      = cnt_q[2];
  assign c2_addr      = cnt_q[3];
  assign w3_addr      = cnt_q[4];
  assign c3_addr      = cnt_q[5];
  assign w4_addr      = cnt_q[6];
  assign busy         = busy_q;
  assign done         = done_q;
  assign class_out    = class_q;
  assign err          = err_q;
  assign state_dbg    = state_q;
endmodule

// File: tb/tb_bwn_frame_ctrl.sv
// Bench for bwn_frame_ctrl: random samples and strobe mixes checked against a count-modulo-depth model.
module tb_bwn_frame_ctrl;
  localparam int N1 = 1274, N2 = 120, N3 = 80, N4 = 40, DW = 16, AW = 12, TO = 20;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, clr = 1'b0;
  logic bn1_en = 1'b0, bn2_en = 1'b0, bn3_en = 1'b0, fc2_en = 1'b0, fc3_en = 1'b0, fc4_en = 1'b0;
  logic res_valid = 1'b0;
  logic [1:0] res_class = 2'b00;
  logic [AW-1:0] w1_addr, w2_addr, w3_addr, w4_addr, c1_addr, c2_addr, c3_addr;
  logic busy, done;
  logic [1:0] class_out, err, state_dbg;

  bwn_frame_ctrl_if #(.D_WL(DW)) bus ();

  bwn_frame_ctrl #(
    .INPUT_SIZE1(N1), .INPUT_SIZE2(N2), .INPUT_SIZE3(N3), .INPUT_SIZE4(N4),
    .D_WL(DW), .AW(AW), .TIMEOUT(TO)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .bus(bus),
    .bn1_en(bn1_en), .bn2_en(bn2_en), .bn3_en(bn3_en),
    .fc2_en(fc2_en), .fc3_en(fc3_en), .fc4_en(fc4_en),
    .w1_addr(w1_addr), .w2_addr(w2_addr), .w3_addr(w3_addr), .w4_addr(w4_addr),
    .c1_addr(c1_addr), .c2_addr(c2_addr), .c3_addr(c3_addr),
    .res_valid(res_valid), .res_class(res_class),
    .busy(busy), .done(done), .class_out(class_out), .err(err), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // scoreboard and reference model
  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];
  int idx_q[$];
  int cnt_m[7];                                  // strobes seen since last clear: w1,c1,w2,c2,w3,c3,w4
  int depth[7] = '{N1, N2, N2, N3, N3, N4, N4};
  logic [1:0] exp_err = 2'b00, exp_class = 2'b00;

  function automatic logic [AW-1:0] addr_of(input int i);
    case (i)
      0: return w1_addr;
      1: return c1_addr;
      2: return w2_addr;
      3: return c2_addr;
      4: return w3_addr;
      5: return c3_addr;
      default: return w4_addr;
    endcase
  endfunction

  function automatic bit model_zero();
    for (int i = 0; i < 7; i++) if ((cnt_m[i] % depth[i]) != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 7; i++) cnt_m[i] = 0;
  endtask

  // drivers
  task automatic set_en(input logic [6:1] v);
    bn1_en = v[1]; fc2_en = v[2]; bn2_en = v[3]; fc3_en = v[4]; bn3_en = v[5]; fc4_en = v[6];
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || bus.s_ready !== 1'b1 || err !== 2'b00 || state_dbg !== 2'd1) begin
      n_errors++;
      $display("FAIL start: busy=%0b s_ready=%0b err=%0b state=%0d, required 1 1 00 1",
               busy, bus.s_ready, err, state_dbg);
    end
  endtask

  // Sends n samples from the start of a frame; returns one cycle after the last sample left dp_data.
  task automatic load_beats(input bit throttle, input int n);
    int acc = 0;
    bit tog = 1'b1;
    bit now_acc;
    bit finished = 1'b0;
    logic [DW-1:0] d, e;
    int ix;
    for (int cyc = 0; cyc < 4 * N1; cyc++) begin
      now_acc = (acc < n) && (!throttle || tog);
      tog = !tog;
      d = DW'($urandom);
      bus.s_valid = now_acc;
      bus.s_data = d;
      if (now_acc) begin
        exp_q.push_back(d);
        idx_q.push_back(acc);
        acc++;
      end
      @(negedge clk);
      n_checks++;
      if (bus.dp_valid !== now_acc) begin
        n_errors++;
        $display("FAIL dp_valid beat %0d: got %0b required %0b", acc, bus.dp_valid, now_acc);
      end
      if (now_acc) begin
        e = exp_q.pop_front();
        ix = idx_q.pop_front();
        n_checks += 2;
        if (bus.dp_data !== e) begin
          n_errors++;
          $display("FAIL dp_data index %0d: got %0h required %0h", ix, bus.dp_data, e);
        end
        if (w1_addr !== AW'(ix)) begin
          n_errors++;
          $display("FAIL w1_addr on sample: got %0d required %0d", w1_addr, ix);
        end
      end else begin
        n_checks++;
        if (w1_addr !== AW'(acc % N1)) begin
          n_errors++;
          $display("FAIL w1_addr in gap: got %0d required %0d", w1_addr, acc % N1);
        end
      end
      n_checks++;
      if (bus.s_ready !== (acc < N1)) begin
        n_errors++;
        $display("FAIL s_ready after %0d beats: got %0b required %0b", acc, bus.s_ready, acc < N1);
      end
      if (acc == n && !now_acc) begin
        finished = 1'b1;
        break;
      end
    end
    bus.s_valid = 1'b0;
    n_checks++;
    if (!finished) begin
      n_errors++;
      $display("FAIL load_budget: got %0d beats required %0d", acc, n);
    end
  endtask

  // Fires the requested number of strobes per layer counter in a random interleave with no idle cycles.
  task automatic strobe_burst(input int r1, input int r2, input int r3, input int r4, input int r5, input int r6);
    int rem[7];
    logic [6:1] v;
    bit any;
    rem = '{0, r1, r2, r3, r4, r5, r6};
    for (int g = 0; g < 2000; g++) begin
      any = 1'b0;
      for (int i = 1; i < 7; i++) if (rem[i] > 0) any = 1'b1;
      if (!any) break;
      v = '0;
      for (int i = 1; i < 7; i++) if (rem[i] > 0 && $urandom_range(0, 1) == 1) v[i] = 1'b1;
      if (v == '0) begin
        for (int i = 1; i < 7; i++) if (rem[i] > 0 && v == '0) v[i] = 1'b1;
      end
      set_en(v);
      for (int i = 1; i < 7; i++) if (v[i]) begin rem[i]--; cnt_m[i]++; end
      @(negedge clk);
      for (int i = 1; i < 7; i++) begin
        n_checks++;
        if (addr_of(i) !== AW'(cnt_m[i] % depth[i])) begin
          n_errors++;
          $display("FAIL strobe_addr[%0d]: got %0d required %0d", i, addr_of(i), cnt_m[i] % depth[i]);
        end
      end
    end
    set_en('0);
  endtask

  task automatic send_result(input logic [1:0] cls);
    res_valid = 1'b1;
    res_class = cls;
    @(negedge clk);
    res_valid = 1'b0;
    exp_class = cls;
    exp_err = model_zero() ? 2'b00 : 2'b10;
    n_checks++;
    if (done !== 1'b1 || class_out !== exp_class || err !== exp_err || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL result: done=%0b class=%0d err=%0b busy=%0b, required 1 %0d %0b 0",
               done, class_out, err, busy, exp_class, exp_err);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || state_dbg !== 2'd0) begin
      n_errors++;
      $display("FAIL done_pulse: done=%0b state=%0d, required 0 0", done, state_dbg);
    end
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({w1_addr, w2_addr, w3_addr, w4_addr, c1_addr, c2_addr, c3_addr, bus.s_ready, bus.dp_valid,
         bus.dp_data, busy, done, class_out, err, state_dbg} !== '0) begin
      n_errors++;
      $display("FAIL reset_state: outputs %0h required all zero", {w1_addr, w2_addr, w3_addr, w4_addr,
               c1_addr, c2_addr, c3_addr, bus.s_ready, bus.dp_valid, bus.dp_data, busy, done, class_out, err});
    end
    rst_n = 1'b1;
    clear_model();
    @(negedge clk);
  endtask

  task automatic test_frame(input bit throttle, input logic [1:0] cls);
    do_start();
    load_beats(throttle, N1);
    n_checks++;
    if (busy !== 1'b1 || bus.s_ready !== 1'b0 || state_dbg !== 2'd2) begin
      n_errors++;
      $display("FAIL after_load: busy=%0b s_ready=%0b state=%0d, required 1 0 2", busy, bus.s_ready, state_dbg);
    end
    strobe_burst(N2, N2, N3, N3, N4, N4);
    send_result(cls);
  endtask

  task automatic test_wrap();
    logic [6:1] v;
    for (int k = 0; k < 2 * N2; k++) begin
      v = '0;
      v[1] = 1'b1;
      v[6] = 1'($urandom_range(0, 1));
      set_en(v);
      cnt_m[1]++;
      if (v[6]) cnt_m[6]++;
      @(negedge clk);
      n_checks += 2;
      if (c1_addr !== AW'(cnt_m[1] % N2)) begin
        n_errors++;
        $display("FAIL wrap_c1 step %0d: got %0d required %0d", k, c1_addr, cnt_m[1] % N2);
      end
      if (w4_addr !== AW'(cnt_m[6] % N4)) begin
        n_errors++;
        $display("FAIL wrap_w4 step %0d: got %0d required %0d", k, w4_addr, cnt_m[6] % N4);
      end
    end
    set_en('0);
    exp_err = 2'b11;
    n_checks++;
    if (err !== exp_err || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_strobe_err: err=%0b busy=%0b, required 11 0", err, busy);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    clear_model();
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (addr_of(i) !== '0) begin
        n_errors++;
        $display("FAIL clr_addr[%0d]: got %0d required 0", i, addr_of(i));
      end
    end
  endtask

  task automatic test_timeout();
    do_start();
    load_beats(1'b0, N1);
    set_en(6'b001000);
    repeat (3) @(negedge clk);
    set_en('0);
    cnt_m[4] += 3;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      n_checks++;
      if (k < TO) begin
        if (done !== 1'b0 || busy !== 1'b1 || w3_addr !== AW'(cnt_m[4])) begin
          n_errors++;
          $display("FAIL timeout_wait cycle %0d: done=%0b busy=%0b w3=%0d, required 0 1 %0d",
                   k, done, busy, w3_addr, cnt_m[4]);
        end
      end else begin
        exp_err = 2'b01;
        clear_model();
        if (done !== 1'b1 || err !== exp_err || busy !== 1'b0 || state_dbg !== 2'd0 ||
            {w1_addr, w2_addr, w3_addr, w4_addr, c1_addr, c2_addr, c3_addr} !== '0) begin
          n_errors++;
          $display("FAIL timeout_fire: done=%0b err=%0b busy=%0b state=%0d w3=%0d, required 1 01 0 0 0",
                   done, err, busy, state_dbg, w3_addr);
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_pulse: done=%0b required 0", done);
    end
  endtask

  task automatic test_incomplete();
    do_start();
    load_beats(1'b0, N1);
    strobe_burst(0, 0, 0, 5, 0, 0);
    n_checks++;
    if (w3_addr !== AW'(5)) begin
      n_errors++;
      $display("FAIL incomplete_w3: got %0d required 5", w3_addr);
    end
    send_result(2'($urandom_range(1, 2)));
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    clear_model();
    n_checks++;
    if (w3_addr !== '0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL incomplete_clr: w3=%0d done=%0b required 0 0", w3_addr, done);
    end
  endtask

  task automatic test_abort_reset();
    do_start();
    load_beats(1'b0, 600);
    clr = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data = DW'($urandom);
    @(negedge clk);
    clr = 1'b0;
    bus.s_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || state_dbg !== 2'd0 || bus.dp_valid !== 1'b0 || bus.s_ready !== 1'b0 ||
        w1_addr !== '0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL abort: busy=%0b state=%0d dp_valid=%0b s_ready=%0b w1=%0d done=%0b, required all 0",
               busy, state_dbg, bus.dp_valid, bus.s_ready, w1_addr, done);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin
        n_errors++;
        $display("FAIL abort_no_done: done=%0b required 0", done);
      end
    end
    start = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clr = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || state_dbg !== 2'd0) begin
      n_errors++;
      $display("FAIL start_clr: busy=%0b state=%0d required 0 0", busy, state_dbg);
    end
    do_start();
    load_beats(1'b0, N1);
    strobe_burst(7, 3, 0, 0, 0, 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    exp_err = 2'b00;
    exp_class = 2'b00;
    n_checks++;
    if ({w1_addr, w2_addr, w3_addr, w4_addr, c1_addr, c2_addr, c3_addr, bus.s_ready, bus.dp_valid,
         bus.dp_data, busy, done, class_out, err, state_dbg} !== '0) begin
      n_errors++;
      $display("FAIL reset_in_wait: c1=%0d w2=%0d w4=%0d busy=%0b class=%0d err=%0b, required all 0",
               c1_addr, w2_addr, w4_addr, busy, class_out, err);
    end
    set_en(6'b000010);
    @(negedge clk);
    set_en('0);
    cnt_m[2]++;
    exp_err = 2'b11;
    n_checks++;
    if (err !== exp_err || w2_addr !== AW'(cnt_m[2]) || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_fc2: err=%0b w2=%0d busy=%0b, required 11 1 0", err, w2_addr, busy);
    end
    do_start();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    clear_model();
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_frame(1'b0, 2'd2);
    test_frame(1'b1, 2'd3);
    test_wrap();
    test_timeout();
    test_incomplete();
    test_abort_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
